// File: rtl/timer_ctrl_pkg.sv
// Shared state encoding, mode constants and widths for the timer run/pause/mode sequencer.
package timer_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int MODE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [MODE_W-1:0] MODE_STOPWATCH = 4'd0;
  localparam logic [MODE_W-1:0] MODE_COUNTDOWN = 4'd1;

  // Advance the mode index, wrapping from num_modes-1 back to 0.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                  input int num_modes);
    if (cur >= MODE_W'(num_modes - 1)) return '0;
    return cur + MODE_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> hold counter -> one-cycle registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      // Only a rising stable level produces a press; releases are silent.
      press_q      <= stable_q & ~stable_dly_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Run/pause/mode sequencer between the debounced board buttons and the timer counters.
// Build option ALARM_BLINK_EN: alarm toggles on every one_sec while DONE instead of holding at 1.
module timer_ctrl_fsm
  import timer_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_MODES       = 2,
  parameter int COUNTDOWN_MODE  = int'(MODE_COUNTDOWN),
  parameter int ALARM_SECS      = 10
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               mode,
  input  logic               one_sec,
  input  logic               count_zero,
  output logic               run_en,
  output logic               clear,
  output logic               count_down,
  output logic [MODE_W-1:0]  mode_at,
  output logic               alarm,
  output logic [STATE_W-1:0] state_o
);

  // state     | meaning
  // ST_IDLE   | stopped; mode button cycles mode_at and clears counters
  // ST_RUN    | counters advance on one_sec
  // ST_PAUSED | counters frozen; start resumes, mode abandons to IDLE
  // ST_DONE   | countdown expired; alarm raised until a press or ALARM_SECS ticks

  localparam int TICK_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(ALARM_SECS - 1);

  logic press_start, press_pause, press_mode;
  logic ev_start, ev_pause, ev_mode, any_press;

  state_e             state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               run_en_q, run_en_d;
  logic               clear_q, clear_d;
  logic               alarm_q, alarm_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               count_down_w;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk_i(clk_100MHz), .rst_i(reset), .btn_i(start), .press_o(press_start)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk_i(clk_100MHz), .rst_i(reset), .btn_i(pause), .press_o(press_pause)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i(clk_100MHz), .rst_i(reset), .btn_i(mode), .press_o(press_mode)
  );

  // Same-cycle presses collapse to the single highest-priority one.
  assign ev_pause  = press_pause;
  assign ev_start  = press_start & ~press_pause;
  assign ev_mode   = press_mode & ~press_start & ~press_pause;
  assign any_press = press_start | press_pause | press_mode;

  assign count_down_w = (mode_q == MODE_W'(COUNTDOWN_MODE));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clear_d = 1'b0;
    alarm_d = 1'b0;
    tick_d  = tick_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_mode) begin
          mode_d  = next_mode(mode_q, NUM_MODES);
          clear_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_pause) begin
          state_d = ST_PAUSED;
        end else if (count_down_w && count_zero) begin
          state_d = ST_DONE;
          tick_d  = TICK_LOAD;
          alarm_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_mode) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      ST_DONE: begin
        alarm_d = alarm_q;
        if (any_press || (one_sec && (tick_q == '0))) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
          alarm_d = 1'b0;
        end else if (one_sec) begin
          tick_d = tick_q - 1'b1;
`ifdef ALARM_BLINK_EN
          alarm_d = ~alarm_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STOPWATCH;
      run_en_q <= 1'b0;
      clear_q  <= 1'b0;
      alarm_q  <= 1'b0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      run_en_q <= run_en_d;
      clear_q  <= clear_d;
      alarm_q  <= alarm_d;
      tick_q   <= tick_d;
    end
  end

  assign run_en     = run_en_q;
  assign clear      = clear_q;
  assign count_down = count_down_w;
  assign mode_at    = mode_q;
  assign alarm      = alarm_q;
  assign state_o    = state_q;

endmodule
